// File: rtl/uart_rx_sampler.sv
// 16x-oversampling 8-bit UART receiver with 3-sample majority vote and framing check.
// Define UART_RX_PARITY_EN for 8E1 frames with a live parity_error strobe; default is 8N1.
module uart_rx_sampler #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       framing_error,
    output logic       parity_error,
    output logic       busy
);

    localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state;
    logic [1:0]      sync;
    logic [1:0]      primed;
    logic            rx_prev;
    logic [PW-1:0]   pre;
    logic [3:0]      sc;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;
    logic            s7;
    logic            s8;
`ifdef UART_RX_PARITY_EN
    logic            par_bad;
`endif

    logic rx_s;
    logic start_edge;
    logic tick;
    logic vote;
    logic at_center;
    logic at_end;

    assign rx_s       = sync[1];
    assign start_edge = rx_prev & ~rx_s;
    assign tick       = (pre == PRE_LAST);
    assign vote       = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
    assign at_center  = tick && (sc == 4'd9);
    assign at_end     = tick && (sc == 4'd15);

    // rx_prev stays low until the synchroniser holds real line data, so a line
    // that is already low when reset releases never looks like a falling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync    <= 2'b11;
            primed  <= 2'b00;
            rx_prev <= 1'b0;
        end else begin
            sync    <= {sync[0], serial_in};
            primed  <= {primed[0], 1'b1};
            rx_prev <= sync[1] & primed[1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            pre           <= '0;
            sc            <= 4'd0;
            bit_cnt       <= 3'd0;
            shift         <= 8'h00;
            s7            <= 1'b1;
            s8            <= 1'b1;
            data_out      <= 8'h00;
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
            busy          <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad       <= 1'b0;
            parity_error  <= 1'b0;
`endif
        end else begin
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error  <= 1'b0;
`endif
            if (state != S_IDLE) begin
                pre <= tick ? '0 : pre + 1'b1;
            end
            if (tick && state != S_IDLE && state != S_BREAK) begin
                sc <= sc + 4'd1;
            end
            if (tick && sc == 4'd7) s7 <= rx_s;
            if (tick && sc == 4'd8) s8 <= rx_s;

            case (state)
                S_IDLE: begin
                    if (start_edge) begin
                        pre   <= '0;
                        sc    <= 4'd0;
                        state <= S_START;
                        busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (at_center && vote) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (at_end) begin
                        state   <= S_DATA;
                        bit_cnt <= 3'd0;
                    end
                end
                S_DATA: begin
                    if (at_center) shift <= {vote, shift[7:1]};
                    if (at_end) begin
                        if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (at_center) par_bad <= vote ^ (^shift);
                    if (at_end) state <= S_STOP;
                end
`endif
                S_STOP: begin
                    // Leave mid-stop-bit so an immediately following start edge is caught.
                    if (at_center) begin
                        if (vote) begin
                            data_out   <= shift;
                            data_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_error <= par_bad;
`endif
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            framing_error <= 1'b1;
                            state         <= S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler at 16 clk per bit: scenario tasks plus randomized frames
// checked against a queue of expected strobes built from the bytes sent.
`timescale 1ns/1ps
module tb_uart_rx_sampler;

    localparam int CLK_HZ   = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int BIT_CLKS = 16;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_CLKS = 11 * BIT_CLKS;
`else
    localparam int FRAME_CLKS = 10 * BIT_CLKS;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       serial_in = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       framing_error;
    logic       parity_error;
    logic       busy;

    always #5 clk = ~clk;

    uart_rx_sampler #(
        .CLK_HZ(CLK_HZ),
        .BAUD(BAUD),
        .OVERSAMPLE(16)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .serial_in(serial_in),
        .data_out(data_out),
        .data_valid(data_valid),
        .framing_error(framing_error),
        .parity_error(parity_error),
        .busy(busy)
    );

    typedef struct {
        logic       dv;
        logic       fe;
        logic       pe;
        logic [7:0] data;
        longint     cyc;
    } ev_t;

    ev_t    obs[$];
    ev_t    exp_q[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    longint cyc = 0;
    logic [7:0] last_good = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every strobe cycle; tests compare the log against their expectations.
    always @(negedge clk) begin
        if (data_valid === 1'b1 || framing_error === 1'b1 || parity_error === 1'b1) begin
            obs.push_back('{dv: data_valid, fe: framing_error, pe: parity_error,
                            data: data_out, cyc: cyc});
            $display("[%0t] strobe dv=%b fe=%b pe=%b data=%02h", $time,
                     data_valid, framing_error, parity_error, data_out);
        end
    end

    task automatic drive_bit(input logic v);
        @(negedge clk);
        serial_in = v;
        repeat (BIT_CLKS - 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic pflip);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^b) ^ pflip);
`else
        if (pflip) $display("note: parity flip ignored in 8N1 build");
`endif
        drive_bit(stop);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        serial_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        serial_in = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (data_out !== 8'h00) begin
            n_bad++; $display("FAIL reset_data_out got=%02h want=00", data_out);
        end
        n_cmp++;
        if ({data_valid, framing_error, parity_error, busy} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_strobes got dv/fe/pe/busy=%b%b%b%b want=0000",
                     data_valid, framing_error, parity_error, busy);
        end
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL low_line_after_reset_busy got=%b want=0", busy);
        end
        n_cmp++;
        if (obs.size() != 0) begin
            n_bad++; $display("FAIL low_line_after_reset_strobes got=%0d want=0", obs.size());
        end
        idle(20);
        $display("test_reset done");
    endtask

    task automatic test_single();
        obs.delete();
        send_frame(8'h35, 1'b1, 1'b0);
        idle(20);
        n_cmp++;
        if (obs.size() != 1) begin
            n_bad++; $display("FAIL single_count got=%0d want=1", obs.size());
        end else begin
            n_cmp++;
            if ({obs[0].dv, obs[0].fe, obs[0].pe} !== 3'b100 || obs[0].data !== 8'h35) begin
                n_bad++;
                $display("FAIL single_event got dv/fe/pe=%b%b%b data=%02h want=100 data=35",
                         obs[0].dv, obs[0].fe, obs[0].pe, obs[0].data);
            end
        end
        n_cmp++;
        if (data_out !== 8'h35 || busy !== 1'b0) begin
            n_bad++; $display("FAIL single_hold got data=%02h busy=%b want=35/0", data_out, busy);
        end
        last_good = 8'h35;
        $display("test_single sent 35");
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        bytes[0] = 8'h31; bytes[1] = 8'h32; bytes[2] = 8'h33;
        obs.delete();
        for (int i = 0; i < 3; i++) send_frame(bytes[i], 1'b1, 1'b0);
        idle(20);
        n_cmp++;
        if (obs.size() != 3) begin
            n_bad++; $display("FAIL b2b_count got=%0d want=3", obs.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (obs[i].dv !== 1'b1 || obs[i].fe !== 1'b0 || obs[i].pe !== 1'b0
                    || obs[i].data !== bytes[i]) begin
                    n_bad++;
                    $display("FAIL b2b_byte%0d got dv=%b fe=%b pe=%b data=%02h want=1/0/0 data=%02h",
                             i, obs[i].dv, obs[i].fe, obs[i].pe, obs[i].data, bytes[i]);
                end
                if (i > 0) begin
                    n_cmp++;
                    if (obs[i].cyc - obs[i-1].cyc != longint'(FRAME_CLKS)) begin
                        n_bad++;
                        $display("FAIL b2b_spacing%0d got=%0d want=%0d", i,
                                 obs[i].cyc - obs[i-1].cyc, FRAME_CLKS);
                    end
                end
            end
        end
        last_good = 8'h33;
        $display("test_back_to_back sent 31 32 33");
    endtask

    task automatic test_glitch();
        int busy_cnt;
        busy_cnt = 0;
        obs.delete();
        @(negedge clk);
        serial_in = 1'b0;
        repeat (4) @(negedge clk);
        serial_in = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
        end
        n_cmp++;
        if (busy_cnt < 1 || busy_cnt > 10) begin
            n_bad++; $display("FAIL glitch_busy_cycles got=%0d want=1..10", busy_cnt);
        end
        n_cmp++;
        if (obs.size() != 0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL glitch_quiet got strobes=%0d busy=%b want=0/0", obs.size(), busy);
        end
        $display("test_glitch busy for %0d clk", busy_cnt);
    endtask

    task automatic test_framing();
        obs.delete();
        send_frame(8'h41, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        n_cmp++;
        if (obs.size() != 1) begin
            n_bad++; $display("FAIL framing_count got=%0d want=1", obs.size());
        end else begin
            n_cmp++;
            if (obs[0].fe !== 1'b1 || obs[0].dv !== 1'b0 || obs[0].pe !== 1'b0) begin
                n_bad++;
                $display("FAIL framing_event got dv/fe/pe=%b%b%b want=010",
                         obs[0].dv, obs[0].fe, obs[0].pe);
            end
        end
        n_cmp++;
        if (data_out !== last_good) begin
            n_bad++; $display("FAIL framing_data_hold got=%02h want=%02h", data_out, last_good);
        end
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL framing_break_busy got=%b want=1", busy);
        end
        idle(40);
        n_cmp++;
        if (obs.size() != 1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL framing_recover got strobes=%0d busy=%b want=1/0", obs.size(), busy);
        end
        $display("test_framing sent 41 with low stop");
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        b = 8'h39;
        obs.delete();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        @(negedge clk);
        serial_in = b[4];
        repeat (8) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL midframe_busy_before got=%b want=1", busy);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || data_out !== 8'h00 || data_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL midframe_async_reset got busy=%b data=%02h dv=%b want=0/00/0",
                     busy, data_out, data_valid);
        end
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        idle(30);
        n_cmp++;
        if (obs.size() != 0) begin
            n_bad++; $display("FAIL midframe_discard got strobes=%0d want=0", obs.size());
        end
        send_frame(8'h37, 1'b1, 1'b0);
        idle(20);
        n_cmp++;
        if (obs.size() != 1 || data_out !== 8'h37) begin
            n_bad++; $display("FAIL midframe_next got strobes=%0d data=%02h want=1/37", obs.size(), data_out);
        end else begin
            n_cmp++;
            if (obs[0].dv !== 1'b1 || obs[0].data !== 8'h37) begin
                n_bad++; $display("FAIL midframe_next_event got dv=%b data=%02h want=1/37", obs[0].dv, obs[0].data);
            end
        end
        last_good = 8'h37;
        $display("test_reset_mid_frame then 37");
    endtask

    task automatic test_random();
        logic [7:0] b;
        obs.delete();
        exp_q.delete();
        for (int i = 0; i < 24; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back('{dv: 1'b1, fe: 1'b0, pe: 1'b0, data: b, cyc: 0});
            send_frame(b, 1'b1, 1'b0);
            $display("random frame %0d byte=%02h", i, b);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 12));
        end
        idle(30);
        n_cmp++;
        if (obs.size() != exp_q.size()) begin
            n_bad++; $display("FAIL random_count got=%0d want=%0d", obs.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (obs[i].dv !== 1'b1 || obs[i].fe !== 1'b0 || obs[i].pe !== 1'b0
                    || obs[i].data !== exp_q[i].data) begin
                    n_bad++;
                    $display("FAIL random_byte%0d got dv=%b fe=%b pe=%b data=%02h want=1/0/0 data=%02h",
                             i, obs[i].dv, obs[i].fe, obs[i].pe, obs[i].data, exp_q[i].data);
                end
            end
        end
        n_cmp++;
        if (data_out !== exp_q[exp_q.size()-1].data) begin
            n_bad++;
            $display("FAIL random_last_hold got=%02h want=%02h", data_out, exp_q[exp_q.size()-1].data);
        end
        last_good = exp_q[exp_q.size()-1].data;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        obs.delete();
        send_frame(8'h33, 1'b1, 1'b0);
        send_frame(8'h33, 1'b1, 1'b1);
        idle(20);
        n_cmp++;
        if (obs.size() != 2) begin
            n_bad++; $display("FAIL parity_count got=%0d want=2", obs.size());
        end else begin
            n_cmp++;
            if (obs[0].dv !== 1'b1 || obs[0].pe !== 1'b0 || obs[0].data !== 8'h33) begin
                n_bad++; $display("FAIL parity_good got dv=%b pe=%b data=%02h want=1/0/33",
                                  obs[0].dv, obs[0].pe, obs[0].data);
            end
            n_cmp++;
            if (obs[1].dv !== 1'b1 || obs[1].pe !== 1'b1 || obs[1].data !== 8'h33) begin
                n_bad++; $display("FAIL parity_bad got dv=%b pe=%b data=%02h want=1/1/33",
                                  obs[1].dv, obs[1].pe, obs[1].data);
            end
        end
        $display("test_parity sent 33 good and flipped");
    endtask
`endif

    initial begin
        #500_000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_reset_mid_frame();
        test_random();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
